// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and helpers for the 7-segment scan driver.
//   SEG_LUT   : 16-entry active-low segment patterns (bit6..0, 0 = lit), index = hex nibble
//   SEG_OFF   : all segments dark
//   idx_width : width of the digit index counter (never less than 1 bit)
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
        7'h03, 7'h08, 7'h18, 7'h00,   // B A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_lut.sv
// seg7_lut: combinational hex nibble to active-low 7-segment decoder.
//   nib_i : 4-bit hex digit
//   seg_o : segments 6..0, active low
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/disp7seg_scan.sv
// disp7seg_scan: time-multiplexed driver for NUM_DIGITS common-anode digits.
//   clk_i    : system clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   value_i  : packed hex value, nibble k drives digit k
//   load_i   : value_i valid, accepted when load_i && ready_o
//   ready_o  : high when no load is pending
//   seg_o    : segments 6..0, active low (registered)
//   an_o     : digit anodes, active low (registered)
//   frame_o  : one-cycle pulse after the digit index wraps to 0 (registered)
// Build option: define SEG7_LZB_EN to blank leading zero digits (digit 0 always shown).
module disp7seg_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    output logic                    ready_o,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      pend_q, pend_d;
    logic [VAL_W-1:0]      disp_q, disp_d;
    logic                  ready_q, ready_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    logic       tick;
    logic       wrap;
    logic       accept;
    logic [3:0] nib;
    logic [6:0] seg_lut;
    logic       blank_lz;

    assign tick   = (cnt_q == CNT_LAST);
    assign wrap   = tick && (idx_q == IDX_LAST);
    assign accept = load_i && ready_q;

    // Prescaler and digit index, both wrapped explicitly.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Load handshake. A load landing on the wrap tick bypasses the pending
    // register so it can join the frame that is just starting.
    always_comb begin
        pend_d  = pend_q;
        disp_d  = disp_q;
        ready_d = ready_q;
        if (accept && wrap) begin
            disp_d = value_i;
        end else if (accept) begin
            pend_d  = value_i;
            ready_d = 1'b0;
        end else if (wrap && !ready_q) begin
            disp_d  = pend_q;
            ready_d = 1'b1;
        end
    end

    // Select the nibble of the digit currently being scanned.
    always_comb begin
        nib = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib = disp_q[4*k +: 4];
            end
        end
    end

    seg7_lut u_lut (
        .nib_i (nib),
        .seg_o (seg_lut)
    );

`ifdef SEG7_LZB_EN
    // Walk from the most significant digit down; a digit is a leading zero
    // while it and every digit above it are zero.
    logic zacc;
    always_comb begin
        zacc     = 1'b1;
        blank_lz = 1'b0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zacc = zacc && (disp_q[4*k +: 4] == 4'h0);
            if (zacc && (idx_q == IDX_W'(k))) begin
                blank_lz = 1'b1;
            end
        end
    end
`else
    assign blank_lz = 1'b0;
`endif

    // Output stage: the cycle following a tick is fully dark (break-before-make).
    always_comb begin
        seg_d   = SEG_OFF;
        an_d    = '1;
        frame_d = wrap;
        if (!tick) begin
            seg_d = blank_lz ? SEG_OFF : seg_lut;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    an_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= '0;
            disp_q  <= '0;
            ready_q <= 1'b1;
            seg_q   <= SEG_OFF;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            ready_q <= ready_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign ready_o = ready_q;
    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_disp7seg_scan.sv
module tb_disp7seg_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] disp_m;
    logic        ready_m;

    disp7seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .value_i (value),
        .load_i  (load),
        .ready_o (ready),
        .seg_o   (seg),
        .an_o    (an),
        .frame_o (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " seg"}, 16'(seg), 16'h7F);
        chk({tag, " an"}, 16'(an), 16'hF);
        chk({tag, " ready"}, 16'(ready), 16'h1);
        chk({tag, " frame"}, 16'(frame), 16'h0);
    endtask

    // Cycle c counts edges since reset release; slot position c%4==0 is the blank cycle.
    task automatic run(input int n);
        int         p;
        int         d;
        logic [6:0] es;
        logic [3:0] ea;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            p = cyc % 4;
            d = (cyc / 4) % 4;
            if (p == 0) begin
                es = 7'h7F;
                ea = 4'hF;
            end else begin
                ea = ~(4'b0001 << d);
                es = hex7(disp_m[4*d +: 4]);
`ifdef SEG7_LZB_EN
                if (d > 0 && (disp_m >> (4*d)) == 16'h0) es = 7'h7F;
`endif
            end
            chk($sformatf("seg@%0d", cyc), 16'(seg), 16'(es));
            chk($sformatf("an@%0d", cyc), 16'(an), 16'(ea));
            chk($sformatf("frame@%0d", cyc), 16'(frame), (cyc % 16 == 0) ? 16'h1 : 16'h0);
            chk($sformatf("ready@%0d", cyc), 16'(ready), 16'(ready_m));
        end
    endtask

    // One-cycle load pulse driven during the current cycle.
    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        run(1);
        load  = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        value   = 16'h0;
        disp_m  = 16'h0;
        ready_m = 1'b1;

        // Reset held
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst_hold");

        // Release: first frame with display 0, frame pulse at cycle 16
        rst_n = 1'b1;
        cyc   = 0;
        run(17);                         // cycles 1..17

        // Mid-frame load 8A3F, extra load while busy is dropped
        ready_m = 1'b0;
        pulse_load(16'h8A3F);            // cycle 18
        run(1);                          // 19
        pulse_load(16'hFFFF);            // 20, ignored
        run(11);                         // 21..31
        disp_m  = 16'h8A3F;
        ready_m = 1'b1;
        run(19);                         // 32..50

        // Mid-frame load 1234 with an ignored second load
        ready_m = 1'b0;
        pulse_load(16'h1234);            // 51
        run(2);                          // 52..53
        pulse_load(16'h5555);            // 54, ignored
        run(9);                          // 55..63
        disp_m  = 16'h1234;
        ready_m = 1'b1;
        run(15);                         // 64..78
        run(1);                          // 79 = wrap tick

        // Load exactly on the wrap tick: goes straight to display, ready stays high
        disp_m = 16'h00C0;
        pulse_load(16'h00C0);            // 80
        run(15);                         // 81..95 (95 = wrap tick)

        disp_m = 16'h0070;
        pulse_load(16'h0070);            // 96
        run(15);                         // 97..111

        disp_m = 16'h0000;
        pulse_load(16'h0000);            // 112
        run(17);                         // 113..129

        // Pending load, then asynchronous reset during digit 2
        ready_m = 1'b0;
        pulse_load(16'hAAAA);            // 130
        run(8);                          // 131..138, digit 2 slot
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_async");
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst_hold2");

        rst_n   = 1'b1;
        cyc     = 0;
        disp_m  = 16'h0000;
        ready_m = 1'b1;
        run(16);                         // restart at digit 0, frame at 16

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
